gb_int_flags: RTL and testbench

Interrupt-flag register (IF, FF0F) for the DMG. Collects the five peripheral interrupt sources, edge-detects the level-type sources (STAT line, joypad matrix) and latches them into sticky flag bits. Presents the flags as the `irq` vector to the CPU interrupt controller and clears bits on the controller's one-hot `iack`. Offers a CPU read/write port for FF0F.

---
 rtl/gb_int_pkg.sv | 14 +
 rtl/gb_sync.sv | 30 +++
 rtl/gb_int_flags.sv | 76 +++++++
 tb/tb_gb_int_flags.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/gb_int_pkg.sv
// Shared constants for the DMG interrupt-flag register (FF0F).
package gb_int_pkg;

  localparam int unsigned IF_W       = 5;
  localparam int unsigned INT_VBLANK = 0;
  localparam int unsigned INT_STAT   = 1;
  localparam int unsigned INT_TIMER  = 2;
  localparam int unsigned INT_SERIAL = 3;
  localparam int unsigned INT_JOYPAD = 4;

  localparam logic [7:0] IF_IMPL_MASK = 8'h1F;
  localparam logic [7:0] IF_READ_ONES = 8'hE0;

endpackage

// File: rtl/gb_sync.sv
// N-stage flip-flop synchroniser for asynchronous input lines.
module gb_sync #(
  parameter int unsigned        STAGES    = 2,
  parameter int unsigned        WIDTH     = 1,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        r_stage[i] <= RESET_VAL;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/gb_int_flags.sv
// IF register (FF0F): latches peripheral interrupt requests, edge-detects STAT
// and joypad levels, clears on controller acknowledge, and exposes a CPU port.
module gb_int_flags
  import gb_int_pkg::*;
#(
  parameter int unsigned     JOY_SYNC_STAGES = 2,
  parameter logic [IF_W-1:0] IF_RESET        = 5'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_vblank,
  input  logic       stat_line,
  input  logic       req_timer,
  input  logic       req_serial,
  input  logic [3:0] joy_in,
  input  logic       cpu_wr,
  input  logic [7:0] cpu_din,
  output logic [7:0] cpu_dout,
  output logic [7:0] irq,
  input  logic [7:0] iack
);

  logic [IF_W-1:0] r_if;
  logic            r_stat;
  logic            r_joy_prev;

  logic [3:0]      w_joy_sync;
  logic            w_joy_and;
  logic [IF_W-1:0] w_set;
  logic [IF_W-1:0] w_if_d;
  logic            w_unused_bits;

  // Joypad lines idle high (released); reset to released so no edge appears.
  gb_sync #(
    .STAGES    (JOY_SYNC_STAGES),
    .WIDTH     (4),
    .RESET_VAL (4'hF)
  ) u_joy_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (joy_in),
    .o_q   (w_joy_sync)
  );

  assign w_joy_and = &w_joy_sync;

  always_comb begin
    w_set             = '0;
    w_set[INT_VBLANK] = req_vblank;
    w_set[INT_STAT]   = stat_line & ~r_stat;
    w_set[INT_TIMER]  = req_timer;
    w_set[INT_SERIAL] = req_serial;
    w_set[INT_JOYPAD] = r_joy_prev & ~w_joy_and;
  end

  // Hardware sets are OR-ed last so they win over a write of 0 or an ack.
  assign w_if_d = ((cpu_wr ? cpu_din[IF_W-1:0] : r_if) & ~iack[IF_W-1:0]) | w_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_if       <= IF_RESET;
      r_stat     <= 1'b0;
      r_joy_prev <= 1'b1;
    end else begin
      r_if       <= w_if_d;
      r_stat     <= stat_line;
      r_joy_prev <= w_joy_and;
    end
  end

  assign cpu_dout = IF_READ_ONES | (8'(r_if) & IF_IMPL_MASK);
  assign irq      = 8'(r_if) & IF_IMPL_MASK;

  assign w_unused_bits = ^{cpu_din[7:IF_W], iack[7:IF_W]};

endmodule

// File: tb/tb_gb_int_flags.sv
// Directed self-checking bench for gb_int_flags.
module tb_gb_int_flags;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_vblank;
  logic       stat_line;
  logic       req_timer;
  logic       req_serial;
  logic [3:0] joy_in;
  logic       cpu_wr;
  logic [7:0] cpu_din;
  logic [7:0] cpu_dout;
  logic [7:0] irq;
  logic [7:0] iack;

  int n_checks = 0;
  int n_pass   = 0;

  gb_int_flags dut (
    .clk        (clk),
    .reset      (reset),
    .req_vblank (req_vblank),
    .stat_line  (stat_line),
    .req_timer  (req_timer),
    .req_serial (req_serial),
    .joy_in     (joy_in),
    .cpu_wr     (cpu_wr),
    .cpu_din    (cpu_din),
    .cpu_dout   (cpu_dout),
    .irq        (irq),
    .iack       (iack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  initial begin
    reset      = 1'b1;
    req_vblank = 1'b0;
    stat_line  = 1'b0;
    req_timer  = 1'b0;
    req_serial = 1'b0;
    joy_in     = 4'hF;
    cpu_wr     = 1'b0;
    cpu_din    = 8'h00;
    iack       = 8'h00;
    repeat (3) tick();
    reset = 1'b0;

    check("rst_dout", cpu_dout, 8'hE0);
    check("rst_irq", irq, 8'h00);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("joy_idle", irq, 8'h00);
    end

    // Timer pulse then acknowledge
    req_timer = 1'b1;
    tick();
    req_timer = 1'b0;
    check("timer_set", irq, 8'h04);
    repeat (2) tick();
    check("timer_hold", irq, 8'h04);
    iack = 8'h04;
    tick();
    iack = 8'h00;
    check("timer_ack", irq, 8'h00);

    // STAT held high sets once; needs a fall before setting again
    stat_line = 1'b1;
    tick();
    check("stat_set", irq, 8'h02);
    repeat (8) tick();
    check("stat_hold", irq, 8'h02);
    iack = 8'h02;
    tick();
    iack = 8'h00;
    check("stat_ack", irq, 8'h00);
    repeat (10) tick();
    check("stat_block", irq, 8'h00);
    stat_line = 1'b0;
    tick();
    check("stat_fall", irq, 8'h00);
    stat_line = 1'b1;
    tick();
    check("stat_reset", irq, 8'h02);
    stat_line = 1'b0;
    iack = 8'h02;
    tick();
    iack = 8'h00;
    check("stat_clr", irq, 8'h00);

    // Set beats ack
    req_vblank = 1'b1;
    iack = 8'h01;
    tick();
    req_vblank = 1'b0;
    iack = 8'h00;
    check("vbl_vs_ack", irq, 8'h01);
    iack = 8'h01;
    tick();
    iack = 8'h00;
    check("vbl_clr", irq, 8'h00);

    // Set beats write of 0
    cpu_wr = 1'b1;
    cpu_din = 8'h00;
    req_serial = 1'b1;
    tick();
    cpu_wr = 1'b0;
    req_serial = 1'b0;
    check("ser_vs_wr", irq, 8'h08);

    // Write of ones with simultaneous ack; read in write cycle sees old value
    cpu_wr = 1'b1;
    cpu_din = 8'hFF;
    iack = 8'h02;
    #1;
    check("rd_old", cpu_dout, 8'hE8);
    tick();
    cpu_wr = 1'b0;
    iack = 8'h00;
    check("wr_ack_dout", cpu_dout, 8'hFD);
    check("wr_ack_irq", irq, 8'h1D);
    cpu_wr = 1'b1;
    cpu_din = 8'h00;
    tick();
    cpu_wr = 1'b0;
    check("wr_clear", irq, 8'h00);

    // Joypad press: set two edges after the sampling edge
    joy_in = 4'hE;
    tick();
    check("joy_k", irq, 8'h00);
    tick();
    check("joy_k1", irq, 8'h00);
    tick();
    check("joy_k2", irq, 8'h10);
    iack = 8'h10;
    tick();
    iack = 8'h00;
    check("joy_ack", irq, 8'h00);
    joy_in = 4'hC;
    repeat (4) tick();
    check("joy_second", irq, 8'h00);
    joy_in = 4'hF;
    repeat (4) tick();
    check("joy_release", irq, 8'h00);
    joy_in = 4'hE;
    repeat (3) tick();
    check("joy_rearm", irq, 8'h10);
    joy_in = 4'hF;
    repeat (4) tick();

    // Reset overrides write and sets
    cpu_wr = 1'b1;
    cpu_din = 8'h1F;
    tick();
    check("all_pending", irq, 8'h1F);
    reset = 1'b1;
    req_timer = 1'b1;
    tick();
    reset = 1'b0;
    cpu_wr = 1'b0;
    req_timer = 1'b0;
    check("rst_mid_dout", cpu_dout, 8'hE0);
    check("rst_mid_irq", irq, 8'h00);
    repeat (4) tick();
    check("rst_quiet", irq, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
